// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared constants for the memory port arbiter
// State encoding, owner codes and the full byte-enable value.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   localparam logic       OWNER_IF = 1'b0;
   localparam logic       OWNER_EX = 1'b1;
   localparam logic [3:0] BE_FULL  = 4'hF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - ack-wait cycle counter for the memory port arbiter
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined; expire_o holds once TIMEOUT is reached.
module mem_arb_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expire_o = (cnt_q == CW'(TIMEOUT));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expire_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
// Optional ack timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_rdata,
   input  logic        ex_rd,
   input  logic        ex_wr,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_wdata,
   input  logic [3:0]  ex_rmask,
   input  logic [3:0]  ex_wmask,
   output logic        ex_done,
   output logic [31:0] ex_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        stall,
   output logic        err
);

   arb_state_e  state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_ex_q, last_ex_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] ex_rdata_q, ex_rdata_d;

   logic ex_pend, grant_ex, grant_if, grant;

   // EX wins a tie unless it was the last one served.
   assign ex_pend  = ex_rd | ex_wr;
   assign grant_ex = ex_pend & ~(if_req & last_ex_q);
   assign grant_if = if_req & ~grant_ex;
   assign grant    = grant_ex | grant_if;

`ifdef MEM_ARB_TIMEOUT_EN
   logic wd_expire;
   logic timeout_q, timeout_d;

   mem_arb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    ((state_q == ST_IDLE) && grant),
      .en_i     ((state_q == ST_BUSY) && !mem_ack),
      .expire_o (wd_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_d;
      end
   end

   assign err = (state_q == ST_RESP) && timeout_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
   assign err            = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_ex_d  = last_ex_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      if_rdata_d = if_rdata_q;
      ex_rdata_d = ex_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
      timeout_d  = timeout_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               state_d   = ST_BUSY;
               owner_d   = grant_ex ? OWNER_EX : OWNER_IF;
               last_ex_d = grant_ex;
               if (grant_ex) begin
                  addr_d  = ex_addr;
                  wdata_d = ex_wdata;
                  we_d    = ex_wr;
                  be_d    = ex_wr ? ex_wmask : ex_rmask;
               end else begin
                  addr_d  = if_addr;
                  we_d    = 1'b0;
                  be_d    = BE_FULL;
               end
            end
         end
         ST_BUSY: begin
            if (mem_ack) begin
               state_d = ST_RESP;
               if (owner_q == OWNER_IF) begin
                  if_rdata_d = mem_rdata;
               end else if (!we_q) begin
                  ex_rdata_d = mem_rdata;
               end
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (wd_expire) begin
               state_d   = ST_RESP;
               timeout_d = 1'b1;
               if (owner_q == OWNER_IF) begin
                  if_rdata_d = '0;
               end else begin
                  ex_rdata_d = '0;
               end
            end
`endif
         end
         ST_RESP: begin
            state_d = ST_IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
            timeout_d = 1'b0;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWNER_IF;
         last_ex_q  <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         if_rdata_q <= '0;
         ex_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_ex_q  <= last_ex_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         if_rdata_q <= if_rdata_d;
         ex_rdata_q <= ex_rdata_d;
      end
   end

   assign mem_req   = (state_q == ST_BUSY);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_be    = be_q;
   assign if_done   = (state_q == ST_RESP) && (owner_q == OWNER_IF);
   assign ex_done   = (state_q == ST_RESP) && (owner_q == OWNER_EX);
   assign if_rdata  = if_rdata_q;
   assign ex_rdata  = ex_rdata_q;
   assign stall     = (ex_pend & ~ex_done) | (if_req & ~if_done);

endmodule
